// File: rtl/imem_fetch_bridge.sv
// -----------------------------------------------------------------------------
// imem_fetch_bridge
//
// Purpose:
//   Connects the pipeline core's instruction fetch port to a slow external
//   instruction memory that uses a req/ack handshake. A one-entry buffer keeps
//   the last fetched address and word. The core is stalled while a fetch is
//   outstanding. Every memory transaction is bounded by a timeout. A timeout
//   returns NOP_WORD to the core and raises the sticky err flag.
//
// Ports:
//   clk        in   rising-edge clock for all state
//   rst        in   synchronous reset, active low (0 = reset)
//   core_addr  in   fetch address from the core PC
//   core_ce    in   core fetch enable
//   core_ins   out  instruction to the core (buffered word, else NOP_WORD)
//   core_stall out  1 = core must hold PC and IF/ID register
//   mem_req    out  memory request, held high until ack or timeout
//   mem_addr   out  word-aligned memory address, stable while mem_req is high
//   mem_ack    in   one-cycle acknowledge; mem_rdata is valid in the same cycle
//   mem_rdata  in   memory read data
//   err        out  sticky error flag (timeout or misaligned fetch)
//
// Optional feature (macro IMEM_ALIGN_CHECK_EN):
//   Defined     : a miss on a misaligned core_addr issues no memory request.
//                 The buffer is loaded with NOP_WORD for that address and err
//                 is set, so the core stalls for a single cycle.
//   Not defined : the low address bits are masked and the aligned word is
//                 fetched normally.
// -----------------------------------------------------------------------------
module imem_fetch_bridge #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                TIMEOUT  = 64,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic              core_ce,
  output logic [DATA_W-1:0] core_ins,
  output logic              core_stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  typedef enum logic {IDLE, WAIT} stateT;

  // Value of the wait counter on the last allowed WAIT cycle.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  stateT             state, stateNext;
  logic              bufValid, bufValidNext;
  logic [ADDR_W-1:0] bufAddr, bufAddrNext;
  logic [DATA_W-1:0] bufData, bufDataNext;
  logic              memReq, memReqNext;
  logic [ADDR_W-1:0] memAddr, memAddrNext;
  logic [7:0]        tmoCnt, tmoCntNext;
  logic              errFlag, errFlagNext;
  logic              hit;

  assign hit        = core_ce & bufValid & (core_addr == bufAddr);
  assign core_ins   = bufValid ? bufData : NOP_WORD;
  assign core_stall = core_ce & ~hit;
  assign mem_req    = memReq;
  assign mem_addr   = memAddr;
  assign err        = errFlag;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      bufValid <= 1'b0;
      bufAddr  <= '0;
      bufData  <= NOP_WORD;
      memReq   <= 1'b0;
      memAddr  <= '0;
      tmoCnt   <= '0;
      errFlag  <= 1'b0;
    end else begin
      state    <= stateNext;
      bufValid <= bufValidNext;
      bufAddr  <= bufAddrNext;
      bufData  <= bufDataNext;
      memReq   <= memReqNext;
      memAddr  <= memAddrNext;
      tmoCnt   <= tmoCntNext;
      errFlag  <= errFlagNext;
    end
  end

  always_comb begin
    stateNext    = state;
    bufValidNext = bufValid;
    bufAddrNext  = bufAddr;
    bufDataNext  = bufData;
    memReqNext   = memReq;
    memAddrNext  = memAddr;
    tmoCntNext   = tmoCnt;
    errFlagNext  = errFlag;

    case (state)
      IDLE: begin
        // Acks arriving while idle are deliberately ignored.
        if (core_ce && !hit) begin
`ifdef IMEM_ALIGN_CHECK_EN
          if (core_addr[1:0] != 2'b00) begin
            // Misaligned fetch: the buffer is filled locally with a NOP so that
            // the core sees a hit on the very next cycle.
            bufAddrNext  = core_addr;
            bufDataNext  = NOP_WORD;
            bufValidNext = 1'b1;
            errFlagNext  = 1'b1;
          end else
`endif
          begin
            memAddrNext = {core_addr[ADDR_W-1:2], 2'b00};
            memReqNext  = 1'b1;
            tmoCntNext  = '0;
            stateNext   = WAIT;
          end
        end
      end

      WAIT: begin
        // An ack is checked before the timeout, so an ack that arrives on the
        // final cycle still delivers data and does not set err.
        if (mem_ack) begin
          bufDataNext  = mem_rdata;
          bufAddrNext  = memAddr;
          bufValidNext = 1'b1;
          memReqNext   = 1'b0;
          stateNext    = IDLE;
        end else if (tmoCnt == TMO_LAST) begin
          bufDataNext  = NOP_WORD;
          bufAddrNext  = memAddr;
          bufValidNext = 1'b1;
          memReqNext   = 1'b0;
          errFlagNext  = 1'b1;
          stateNext    = IDLE;
        end else begin
          tmoCntNext = tmoCnt + 8'd1;
        end
      end

      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_fetch_bridge.sv
// -----------------------------------------------------------------------------
// tb_imem_fetch_bridge
//
// Bench for imem_fetch_bridge. It contains the following parts:
//   - A memory responder. It acks after a programmable number of WAIT cycles
//     and can be muted or told to inject a stray ack.
//   - A transaction-level reference model. It holds one outstanding fetch
//     record and one buffer entry. A checker compares all DUT outputs against
//     this model on every falling edge.
//   - Directed scenarios with literal expected words, stall lengths and
//     request logs.
// -----------------------------------------------------------------------------
module tb_imem_fetch_bridge;

  localparam int          TMO = 64;
  localparam logic [31:0] NOP = 32'h00000000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] core_addr = '0;
  logic        core_ce = 1'b0;
  logic [31:0] core_ins;
  logic        core_stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        err;

  int checks = 0;
  int errors = 0;

  imem_fetch_bridge #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TMO),
    .NOP_WORD(NOP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .core_addr (core_addr),
    .core_ce   (core_ce),
    .core_ins  (core_ins),
    .core_stall(core_stall),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Memory image: address 0 holds 0x34011100.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return 32'h34011100 ^ (a * 32'h00010001);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  int   ackDelay  = 1;
  logic ackEnable = 1'b1;
  logic strayAck  = 1'b0;

  initial begin
    int waitCnt;
    waitCnt = 0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req && ackEnable) begin
        waitCnt = waitCnt + 1;
        if (waitCnt == ackDelay) begin
          mem_ack   = 1'b1;
          mem_rdata = memWord(mem_addr);
        end
      end else begin
        waitCnt = 0;
        if (strayAck) begin
          mem_ack   = 1'b1;
          mem_rdata = 32'hDEADBEEF;
        end
      end
    end
  end

  // ---------------- request log ----------------
  logic [31:0] reqLog[$];
  logic        prevReq = 1'b0;

  always @(negedge clk) begin
    if (mem_req === 1'b1 && prevReq !== 1'b1) reqLog.push_back(mem_addr);
    prevReq <= mem_req;
  end

  // ---------------- reference model ----------------
  // One outstanding fetch record (busy, address, cycles waited) and one buffer
  // entry. The model follows the handshake rules: ack, then timeout, then wait.
  logic        mBusy, mBufValid, mErr;
  logic [31:0] mFetchAddr, mBufAddr, mBufData;
  int          mWaited;
  logic        chkEn = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      mBusy      <= 1'b0;
      mBufValid  <= 1'b0;
      mBufAddr   <= '0;
      mBufData   <= NOP;
      mFetchAddr <= '0;
      mWaited    <= 0;
      mErr       <= 1'b0;
    end else if (!mBusy) begin
      if (core_ce && !(mBufValid && core_addr == mBufAddr)) begin
`ifdef IMEM_ALIGN_CHECK_EN
        if (core_addr % 4 != 0) begin
          mBufAddr  <= core_addr;
          mBufData  <= NOP;
          mBufValid <= 1'b1;
          mErr      <= 1'b1;
        end else
`endif
        begin
          mBusy      <= 1'b1;
          mFetchAddr <= core_addr - (core_addr % 4);
          mWaited    <= 0;
        end
      end
    end else begin
      if (mem_ack) begin
        mBusy     <= 1'b0;
        mBufAddr  <= mFetchAddr;
        mBufData  <= mem_rdata;
        mBufValid <= 1'b1;
      end else if (mWaited + 1 == TMO) begin
        mBusy     <= 1'b0;
        mBufAddr  <= mFetchAddr;
        mBufData  <= NOP;
        mBufValid <= 1'b1;
        mErr      <= 1'b1;
      end else begin
        mWaited <= mWaited + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chkEn) begin
      check("model_ins",   core_ins, mBufValid ? mBufData : NOP);
      check("model_stall", 32'(core_stall),
            32'(core_ce && !(mBufValid && core_addr == mBufAddr)));
      check("model_req",   32'(mem_req), 32'(mBusy));
      check("model_maddr", mem_addr, mFetchAddr);
      check("model_err",   32'(err), 32'(mErr));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst     = 1'b0;
    core_ce = 1'b0;
    step(2);
    rst = 1'b1;
  endtask

  task automatic waitReq(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (mem_req === 1'b1) seen = 1;
    end
    if (!seen) check({name, "_req_timeout"}, 32'd0, 32'd1);
  endtask

  // Presents an address. It counts the stall cycles and the mem_req-high cycles
  // until the core sees a hit, then checks the delivered word.
  task automatic fetch(input string name, input logic [31:0] a, input logic [31:0] expIns,
                       input int expStall, input int expReqHigh);
    int stallCnt, reqHigh;
    bit done;
    core_addr = a;
    core_ce   = 1'b1;
    stallCnt  = 0;
    reqHigh   = 0;
    done      = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (mem_req === 1'b1) reqHigh++;
      if (core_stall === 1'b1) stallCnt++;
      else done = 1;
    end
    if (!done) check({name, "_stall_timeout"}, 32'd0, 32'd1);
    check({name, "_stall_cycles"}, 32'(stallCnt), 32'(expStall));
    check({name, "_req_cycles"}, 32'(reqHigh), 32'(expReqHigh));
    check({name, "_ins"}, core_ins, expIns);
    step(1);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int n;
    doReset();
    chkEn = 1'b1;

    // 1: reset while a fetch is outstanding, then a stray ack.
    ackEnable = 1'b0;
    core_addr = 32'h40;
    core_ce   = 1'b1;
    waitReq("rst_mid");
    step(2);
    rst     = 1'b0;
    core_ce = 1'b0;
    step(2);
    rst = 1'b1;
    @(negedge clk);
    check("rst_req",   32'(mem_req), 32'd0);
    check("rst_stall", 32'(core_stall), 32'd0);
    check("rst_ins",   core_ins, 32'h00000000);
    check("rst_err",   32'(err), 32'd0);
    step(1);
    ackEnable = 1'b1;
    strayAck  = 1'b1;
    step(1);
    strayAck = 1'b0;
    step(1);
    @(negedge clk);
    check("stray_ack_ins", core_ins, 32'h00000000);
    check("stray_ack_req", 32'(mem_req), 32'd0);
    check("stray_ack_err", 32'(err), 32'd0);
    $display("T1 reset mid-WAIT done: ins=%08h err=%0b", core_ins, err);

    // 2: zero-wait memory, 2-cycle stall, then no re-fetch while holding.
    step(1);
    reqLog.delete();
    ackDelay = 1;
    fetch("zw", 32'h0, 32'h34011100, 2, 1);
    n = reqLog.size();
    step(5);
    @(negedge clk);
    check("hold_no_req", 32'(reqLog.size()), 32'(n));
    check("hold_stall",  32'(core_stall), 32'd0);
    $display("T2 zero-wait fetch 0x0 -> %08h", core_ins);

    // 3: sequential fetches with an ack in the third WAIT cycle.
    doReset();
    reqLog.delete();
    ackDelay = 3;
    fetch("seq0", 32'h0, 32'h34011100, 4, 3);
    $display("T3 fetch 0x0 -> %08h", core_ins);
    fetch("seq4", 32'h4, 32'h34051104, 4, 3);
    $display("T3 fetch 0x4 -> %08h", core_ins);
    fetch("seq8", 32'h8, 32'h34091108, 4, 3);
    $display("T3 fetch 0x8 -> %08h", core_ins);
    check("seq_req_count", 32'(reqLog.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < reqLog.size()) check("seq_req_addr", reqLog[i], 32'(i * 4));

    // 5: address changes during WAIT.
    reqLog.delete();
    core_addr = 32'h20;
    core_ce   = 1'b1;
    waitReq("chg");
    step(1);
    core_addr = 32'h24;
    begin
      bit done;
      done = 0;
      for (int i = 0; i < 100 && !done; i++) begin
        @(negedge clk);
        if (core_stall !== 1'b1) done = 1;
      end
      if (!done) check("chg_stall_timeout", 32'd0, 32'd1);
    end
    check("chg_ins", core_ins, 32'h34251124);
    check("chg_req_count", 32'(reqLog.size()), 32'd2);
    if (reqLog.size() == 2) begin
      check("chg_req0", reqLog[0], 32'h20);
      check("chg_req1", reqLog[1], 32'h24);
    end
    $display("T5 addr change 0x20->0x24 -> %08h", core_ins);
    step(1);

    // 6: misaligned address.
`ifdef IMEM_ALIGN_CHECK_EN
    reqLog.delete();
    ackDelay = 1;
    fetch("mis", 32'h6, 32'h00000000, 1, 0);
    check("mis_err", 32'(err), 32'd1);
    check("mis_no_req", 32'(reqLog.size()), 32'd0);
    $display("T6 misaligned 0x6 (check on) -> ins=%08h err=%0b", core_ins, err);
`else
    ackDelay  = 1;
    core_addr = 32'h6;
    core_ce   = 1'b1;
    waitReq("mis");
    check("mis_maddr", mem_addr, 32'h4);
    step(1);
    core_ce = 1'b0;
    @(negedge clk);
    check("mis_err", 32'(err), 32'd0);
    check("mis_ins", core_ins, 32'h34051104);
    $display("T6 misaligned 0x6 (check off) -> mem_addr=4 ins=%08h", core_ins);
    step(2);
`endif

    // 4: timeout with no ack at all.
    ackEnable = 1'b0;
    fetch("tmo", 32'h10, 32'h00000000, TMO + 1, TMO);
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_req", 32'(mem_req), 32'd0);
    $display("T4 timeout on 0x10 -> ins=%08h err=%0b", core_ins, err);
    ackEnable = 1'b1;

    // Only a reset clears the sticky error.
    doReset();
    @(negedge clk);
    check("err_cleared", 32'(err), 32'd0);
    $display("T7 reset clears err -> err=%0b", err);

    step(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/imem_fetch_bridge.md
Name: imem_fetch_bridge

Overview:
Instruction-side bridge between the pipeline core's fetch port (addr_output / enabler_output / ins_input) and a slow external instruction memory with a req/ack handshake.
- Holds a one-entry instruction buffer (last fetched address plus data).
- Stalls the core while a fetch is outstanding.
- Bounds every memory transaction with a timeout.
- Sits directly upstream of the core: core_ins drives the core's ins_input, and core_stall will drive the PC/IF stall input the team is adding next.

Parameters:
ADDR_W, 32, width of instruction address
DATA_W, 32, width of instruction word
TIMEOUT, 64, max cycles to wait for mem_ack before aborting (1..255)
NOP_WORD, 32'h00000000, word returned to core on abort/error

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-low (0 = reset)
core_addr  in  ADDR_W  fetch address from core PC
core_ce  in  1  core fetch enable
core_ins  out  DATA_W  instruction to core
core_stall  out  1  1 = core must hold PC and IF/ID register
mem_req  out  1  memory request, held until ack
mem_addr  out  ADDR_W  word-aligned memory address
mem_ack  in  1  one-cycle ack; mem_rdata valid same cycle
mem_rdata  in  DATA_W  memory read data
err  out  1  sticky error flag (timeout or misalignment)

Behaviour:
Reset (rst==0 at a clk edge):
- state=IDLE, buf_valid=0, buf_addr=0, buf_data=NOP_WORD, mem_req=0, mem_addr=0, tmo_cnt=0, err=0.
- core_ins=NOP_WORD, core_stall=0.
- Reset overrides any outstanding request; a late mem_ack after reset is ignored.

Hit (combinational):
- hit = core_ce & buf_valid & (core_addr == buf_addr).
- core_ins = buf_data whenever buf_valid, else NOP_WORD.
- core_stall = core_ce & ~hit.
- core_ce==0 -> core_stall=0, no request issued.

States:
- IDLE: if core_ce & ~hit -> mem_addr <= {core_addr[ADDR_W-1:2],2'b00}, mem_req <= 1, tmo_cnt <= 0, go WAIT.
- WAIT: mem_req held high, mem_addr stable.
  - mem_ack -> buf_data <= mem_rdata, buf_addr <= mem_addr, buf_valid <= 1, mem_req <= 0, go IDLE. The core sees a hit the next cycle.
  - no ack -> tmo_cnt++.
  - tmo_cnt == TIMEOUT-1 without ack -> mem_req <= 0, buf_data <= NOP_WORD, buf_addr <= mem_addr, buf_valid <= 1, err <= 1, go IDLE.
  - An ack on the timeout cycle wins: data is captured, err is not set.

Latency and rules:
- Miss-to-hit latency = 1 (request cycle) + ack wait + 1 cycles. With zero-wait memory (ack in the first WAIT cycle), core_stall is high for exactly 2 cycles.
- core_addr changing during WAIT does not alter mem_addr. The completed entry then misses and a new fetch starts from IDLE.
- Back-to-back: a new request may issue the cycle after returning to IDLE. At most one transaction is outstanding.
- mem_ack in IDLE is ignored.
- err stays set until reset.

Optional Feature:
Macro IMEM_ALIGN_CHECK_EN.
- Defined: in IDLE, a miss with core_addr[1:0] != 0 issues no memory request. Instead, buf_addr <= core_addr, buf_data <= NOP_WORD, buf_valid <= 1, err <= 1, and stall lasts 1 cycle.
- Not defined: low address bits are silently masked and the aligned word is fetched normally.

Test Plan:
1. rst=0 for 2 cycles mid-WAIT (mem_req=1) -> next cycle mem_req=0, core_stall=0, core_ins=0x00000000, err=0; an ack arriving afterwards changes nothing.
2. core_addr=0x00000000, core_ce=1, memory acks in the first WAIT cycle with 0x34011100 -> core_stall high 2 cycles, then core_ins=0x34011100 and stall=0; holding the address causes no second mem_req.
3. Sequential 0x0, 0x4, 0x8 with 3-cycle ack delay -> each mem_addr is seen exactly once; stall is 4 cycles per fetch; delivered words match memory contents in order.
4. TIMEOUT=64, mem_ack never asserted, addr 0x10 -> mem_req drops after 64 WAIT cycles; err=1; core_ins=0x00000000; stall released.
5. Address changed 0x20 -> 0x24 during WAIT -> fetch of 0x20 completes, then a new mem_req for 0x24; core receives the 0x24 word only after its ack.
6. core_addr=0x00000006: with IMEM_ALIGN_CHECK_EN -> no mem_req, err=1, core_ins=0x00000000 after a 1-cycle stall; without the macro -> mem_addr=0x00000004, err=0.
